// File: rtl/add_pipe.sv
// Pipelined DATA_LEN-bit adder/subtractor: the carry ripples one CHUNK per stage,
// with valid/ready handshakes on both sides and ADD/SUB/ADC/SBB modes.
module add_pipe #(
  parameter int unsigned DATA_LEN = 64,
  parameter int unsigned STAGES   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] op_a,
  input  logic [DATA_LEN-1:0] op_b,
  input  logic [1:0]          mode,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] sum,
  output logic                cout,
  output logic                overflow,
  output logic                zero
);

  localparam int unsigned CHUNK = DATA_LEN / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ADC = 2'b10,
    MODE_SBB = 2'b11
  } mode_e;

  logic [STAGES-1:0]   valid_q, valid_d;
  logic [STAGES-1:0]   adv, load;
  logic [DATA_LEN-1:0] a_q [STAGES];
  logic [DATA_LEN-1:0] b_q [STAGES];
  logic [DATA_LEN-1:0] s_q [STAGES];
  logic [STAGES-1:0]   c_q;
  logic                ovf_q, zero_q;

  logic [DATA_LEN-1:0] a_src [STAGES];
  logic [DATA_LEN-1:0] b_src [STAGES];
  logic [DATA_LEN-1:0] s_src [STAGES];
  logic [DATA_LEN-1:0] s_d   [STAGES];
  logic [STAGES-1:0]   c_src, c_d;
  logic [DATA_LEN-1:0] b_pre;
  logic                c0;
  logic [CHUNK:0]      part;
  logic                ovf_d, zero_d;
  logic                accept;

  // Operand preprocessing: subtraction is a + ~b + 1, borrow-in inverts cin.
  always_comb begin
    b_pre = mode[0] ? ~op_b : op_b;
    c0    = 1'b0;
    case (mode_e'(mode))
      MODE_ADD: c0 = 1'b0;
      MODE_SUB: c0 = 1'b1;
      MODE_ADC: c0 = cin;
      MODE_SBB: c0 = ~cin;
      default:  c0 = 1'b0;
    endcase
  end

  // Backpressure chain, evaluated from the output stage backwards.
  always_comb begin
    adv       = '0;
    adv[LAST] = valid_q[LAST] & out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready = (~valid_q[0] | adv[0]) & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int k = 1; k < int'(STAGES); k++) begin
      load[k] = adv[k-1];
    end
    valid_d = flush ? '0 : (load | (valid_q & ~adv));
  end

  // Each stage adds its own chunk using the carry registered by the stage before.
  always_comb begin
    a_src[0] = op_a;
    b_src[0] = b_pre;
    s_src[0] = '0;
    c_src    = '0;
    c_src[0] = c0;
    for (int k = 1; k < int'(STAGES); k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
    end
    part = '0;
    c_d  = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      part = {1'b0, a_src[k][k*CHUNK +: CHUNK]} + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
           + (CHUNK+1)'(c_src[k]);
      s_d[k]                  = s_src[k];
      s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_d[k]                  = part[CHUNK];
    end
    ovf_d  = (a_src[LAST][DATA_LEN-1] == b_src[LAST][DATA_LEN-1])
           & (s_d[LAST][DATA_LEN-1] != a_src[LAST][DATA_LEN-1]);
    zero_d = (s_d[LAST] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) begin
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (load[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined integer adder/subtractor for the npc datapath.
- Splits a DATA_LEN-wide operation into STAGES equal chunks and ripples the carry through registered stages.
- Sustains one operation per cycle under valid/ready handshakes on both sides.
- Supports ADD, SUB, ADC and SBB modes, with carry, signed-overflow and zero flags.
- Used for wide or 64-bit arithmetic where a single-cycle ripple chain misses timing.

Parameters:
- DATA_LEN, 64, operand and result width; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages; each stage adds CHUNK = DATA_LEN/STAGES bits; 1 <= STAGES <= DATA_LEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drops every in-flight operation.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation this cycle.
- op_a  input  DATA_LEN  operand A.
- op_b  input  DATA_LEN  operand B.
- mode  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
- cin  input  1  carry/borrow input; used only by ADC and SBB.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  DATA_LEN  result.
- cout  output  1  raw carry out of the MSB (for SUB/SBB: 1 = no borrow).
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at an edge, all stage valid bits and all data registers clear to 0. After reset: out_valid=0, sum=0, cout=0, overflow=0, zero=0, in_ready=1.
- Operand preprocessing at acceptance:
  - b' = op_b inverted when mode[0]=1, else op_b.
  - c0 = 0 for ADD, 1 for SUB, cin for ADC, ~cin for SBB.
  - So SBB computes a - b - cin.
- Acceptance: an operation is accepted on a rising edge where in_valid=1, in_ready=1, flush=0 and rst=0.
- Stage datapath (chunk k = bits [k*CHUNK +: CHUNK]):
  - Stage 0 register captures: sum chunk 0, carry out of chunk 0, the upper operand bits still to be processed, sign bits a_msb and b'_msb.
  - Moving into stage k (k >= 1): chunk k is computed from the carried operands and the registered carry, and written into the partial sum.
  - The last stage register holds the full sum and the final carry.
- Flags, formed when entering the last stage:
  - cout = carry out of bit DATA_LEN-1.
  - overflow = (a_msb == b'_msb) & (sum_msb != a_msb).
  - zero = (sum == 0).
- Outputs: sum, cout, overflow and zero are driven directly from last-stage registers; out_valid = valid bit of the last stage.
- Latency: STAGES cycles. With out_ready held at 1, an op accepted at edge N has out_valid=1 during the cycle after edge N+STAGES-1. STAGES=1 gives a result in the cycle after acceptance.
- Throughput: one op per cycle. No bubbles are inserted while out_ready=1.
- Backpressure:
  - Stage k advances when it is valid and (stage k+1 is empty or stage k+1 advances).
  - The last stage advances on out_ready.
  - in_ready = ~valid[0] | advance[0].
  - A full pipeline with out_ready=0 holds all contents stable and drives in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, sum and all flags stay constant.
- Simultaneous accept and drain: when the last stage drains and a new op is accepted in the same cycle, both happen with no loss.
- flush:
  - Clears all valid bits at the edge; in_valid is ignored that cycle; in_ready=0 while flush=1.
  - Data registers need not clear.
  - out_valid=0 on the next cycle.
- rst has priority over flush. Reset mid-operation discards all in-flight ops.
- Ordering: results leave in acceptance order; there is no reordering.

Test Plan:
Bench configuration: DATA_LEN=32, STAGES=4 unless noted.
- Reset, then ADD 0xFFFF_FFFF + 0x0000_0001, out_ready=1 -> after 4 cycles: sum=0, cout=1, overflow=0, zero=1.
- SUB 0x8000_0000 - 0x0000_0001 -> sum=0x7FFF_FFFF, cout=1, overflow=1, zero=0. SBB 5-3 with cin=1 -> sum=1, cout=1.
- ADC 0x7FFF_FFFF + 0 with cin=1 -> sum=0x8000_0000, overflow=1, cout=0. Compare against a reference model for 10k random ops in all modes.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order, first result at cycle 4.
- Hold out_ready=0 while streaming -> exactly 4 ops accepted, then in_ready=0; sum stays stable; releasing out_ready drains them in order with no duplicates.
- Pulse flush with 3 ops in flight -> out_valid=0 next cycle and none of those 3 results appear. Assert rst mid-stream -> all outputs 0 and in_ready=1 on the following cycle. Repeat the first scenario with STAGES=1 -> latency 1.
